// File: rtl/serial_ne.sv
// Bit-serial inequality comparator: operands arrive one bit pair per cycle,
// LSB first; O reports A != B after exactly WIDTH accepted pairs.
module serial_ne #(
  parameter int WIDTH = 8
) (
  input  logic CLK,
  input  logic ASYNCRESET,
  input  logic START,
  input  logic VALID,
  input  logic I0,
  input  logic I1,
  output logic O,
  output logic DONE,
  output logic BUSY
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          o_q, o_d;
  logic          done_q, done_d;
  logic          mis;

  assign mis = acc_q | (I0 ^ I1);

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      o_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SHIFT;
          acc_d   = 1'b0;
          cnt_d   = '0;
          o_d     = 1'b0;
        end
      end
      SHIFT: begin
        // No early-out: a mismatch only sets acc, the full word is always consumed
        if (VALID) begin
          acc_d = mis;
          if (cnt_q == LAST) begin
            o_d     = mis;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign O    = o_q;
  assign DONE = done_q;
  assign BUSY = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_ne.sv
// Directed + random bench for serial_ne at WIDTH 8, 2 and 32; the reference
// result is simply (A != B) over WIDTH bits and latency is WIDTH+1+gap cycles.
module tb_serial_ne;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic       i0 = 1'b0;
  logic       i1 = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] o, done, busy;

  int nerr = 0;
  int nchk = 0;
  int W[3] = '{8, 2, 32};

  always #5 clk = ~clk;

  serial_ne #(.WIDTH(8)) u_w8 (
    .CLK(clk), .ASYNCRESET(rst), .START(start[0]), .VALID(valid),
    .I0(i0), .I1(i1), .O(o[0]), .DONE(done[0]), .BUSY(busy[0]));
  serial_ne #(.WIDTH(2)) u_w2 (
    .CLK(clk), .ASYNCRESET(rst), .START(start[1]), .VALID(valid),
    .I0(i0), .I1(i1), .O(o[1]), .DONE(done[1]), .BUSY(busy[1]));
  serial_ne #(.WIDTH(32)) u_w32 (
    .CLK(clk), .ASYNCRESET(rst), .START(start[2]), .VALID(valid),
    .I0(i0), .I1(i1), .O(o[2]), .DONE(done[2]), .BUSY(busy[2]));

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Called just after a negedge; START is sampled on the following posedge.
  task automatic do_start(input int sel);
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    chk("start_busy", {31'd0, busy[sel]}, 32'd1);
    chk("start_o_clr", {31'd0, o[sel]}, 32'd0);
    chk("start_done", {31'd0, done[sel]}, 32'd0);
  endtask

  // Shifts the pair LSB first; gapmask bit i inserts gaplen idle cycles after bit i.
  task automatic shift_bits(input int sel, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] gapmask, input int gaplen, input bit noise);
    int   w;
    int   edges;
    int   exp_gaps;
    logic exp_o;
    w        = W[sel];
    edges    = 0;
    exp_o    = (((a ^ b) & wmask(w)) != 32'd0);
    exp_gaps = $countones(gapmask & wmask(w - 1)) * gaplen;
    for (int i = 0; i < w; i++) begin
      valid = 1'b1;
      i0    = a[i];
      i1    = b[i];
      if (noise) start[sel] = 1'($urandom);
      @(negedge clk);
      edges++;
      if (i < w - 1) begin
        chk("mid_busy", {31'd0, busy[sel]}, 32'd1);
        chk("no_early_done", {31'd0, done[sel]}, 32'd0);
        if (gapmask[i]) begin
          for (int g = 0; g < gaplen; g++) begin
            valid = 1'b0;
            i0    = 1'($urandom);
            i1    = 1'($urandom);
            if (noise) start[sel] = 1'($urandom);
            @(negedge clk);
            edges++;
            chk("gap_done", {31'd0, done[sel]}, 32'd0);
          end
        end
      end
    end
    valid      = 1'b0;
    start[sel] = 1'b0;
    chk("done_pulse", {31'd0, done[sel]}, 32'd1);
    chk("result_o", {31'd0, o[sel]}, {31'd0, exp_o});
    chk("busy_fall", {31'd0, busy[sel]}, 32'd0);
    chk("latency", edges + 1, w + 1 + exp_gaps);
  endtask

  task automatic after_done(input int sel, input logic exp_o);
    @(negedge clk);
    chk("done_drop", {31'd0, done[sel]}, 32'd0);
    chk("o_hold", {31'd0, o[sel]}, {31'd0, exp_o});
  endtask

  initial begin
    logic [31:0] ra, rb, rgap;
    int          rsel;
    #1 rst = 1'b1;
    #2;
    chk("reset_o", {29'd0, o}, 32'd0);
    chk("reset_done", {29'd0, done}, 32'd0);
    chk("reset_busy", {29'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", {29'd0, busy}, 32'd0);

    // Equal, LSB mismatch, MSB-only mismatch
    do_start(0); shift_bits(0, 32'hA5, 32'hA5, 32'd0, 0, 1'b0); after_done(0, 1'b0);
    do_start(0); shift_bits(0, 32'hA5, 32'hA4, 32'd0, 0, 1'b0); after_done(0, 1'b1);
    repeat (3) @(negedge clk);
    chk("o_hold_idle", {31'd0, o[0]}, 32'd1);
    do_start(0); shift_bits(0, 32'h80, 32'h00, 32'd0, 0, 1'b0); after_done(0, 1'b1);

    // Gaps after bits 2 and 5 with input/START noise
    do_start(0); shift_bits(0, 32'h3C, 32'h3D, 32'h24, 3, 1'b1); after_done(0, 1'b1);

    // Back-to-back: second START lands in the DONE cycle
    do_start(0); shift_bits(0, 32'h11, 32'h10, 32'd0, 0, 1'b1);
    do_start(0); shift_bits(0, 32'hFF, 32'hFF, 32'd0, 0, 1'b0); after_done(0, 1'b0);

    // Idle reset clears a held O=1
    do_start(0); shift_bits(0, 32'h01, 32'h00, 32'd0, 0, 1'b0); after_done(0, 1'b1);
    #2 rst = 1'b1;
    #1 chk("idle_rst_o", {31'd0, o[0]}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-operation after 4 bits of a mismatching pair
    do_start(0);
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; i0 = 1'b1; i1 = 1'b0;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
    chk("midrst_o", {31'd0, o[0]}, 32'd0);
    chk("midrst_done", {31'd0, done[0]}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("postrst_idle", {31'd0, busy[0]}, 32'd0);
    chk("postrst_nodone", {31'd0, done[0]}, 32'd0);
    valid = 1'b0;
    do_start(0); shift_bits(0, 32'h00, 32'h00, 32'd0, 0, 1'b0); after_done(0, 1'b0);

    // Width sweep
    do_start(1); shift_bits(1, 32'h2, 32'h2, 32'd0, 0, 1'b0); after_done(1, 1'b0);
    do_start(1); shift_bits(1, 32'h2, 32'h0, 32'd0, 0, 1'b0); after_done(1, 1'b1);
    do_start(2); shift_bits(2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 0, 1'b0); after_done(2, 1'b0);
    do_start(2); shift_bits(2, 32'h8000_0000, 32'h0, 32'd0, 0, 1'b0); after_done(2, 1'b1);

    // Random: equal, single-bit-flip and unrelated operand pairs
    for (int n = 0; n < 24; n++) begin
      rsel = $urandom_range(0, 2);
      ra   = $urandom & wmask(W[rsel]);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(0, W[rsel] - 1));
        default: rb = $urandom & wmask(W[rsel]);
      endcase
      rgap = ($urandom_range(0, 1) != 0) ? $urandom : 32'd0;
      do_start(rsel);
      shift_bits(rsel, ra, rb, rgap, $urandom_range(1, 3), 1'b1);
      after_done(rsel, ra != rb);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
